// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, state and flag types for the handshaked ALU.
package alu_pkg;
   localparam int RISC_V_DATA_WIDTH = 32;
   typedef enum logic [3:0] {
      AND = 4'd0, OR, ADD, SUB, XOR, SLL, SRL, SRA, SLT, SLTU, PASSB, MUL
   } ALU_ctrl_t;
   typedef enum logic {IDLE, MUL_BUSY} alu_state_t;
   typedef struct packed {
      logic zero;
      logic negative;
      logic overflow;
      logic illegal;
   } alu_flags_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier producing the low word, one bit per clock.
module alu_mul_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         run,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] prod,
   output logic         done
);
   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   logic [W-1:0] mcand, mplier, acc;
   logic [CW-1:0] cnt;
   // prod is the accumulator value after this step, so the final step can be registered directly
   assign prod = mplier[0] ? acc + mcand : acc;
   assign done = run && cnt == LAST;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (run) begin
         acc    <= prod;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/alu_hs.sv
// alu_hs: valid/ready integer ALU with flags and an optional iterative MUL.
module alu_hs
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = RISC_V_DATA_WIDTH,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
   parameter bit MUL_EN      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_in_A,
   input  logic [DATA_WIDTH-1:0] data_in_B,
   input  ALU_ctrl_t             ALU_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  zero,
   output logic                  negative,
   output logic                  overflow,
   output logic                  illegal
);
   localparam int M = DATA_WIDTH - 1;
   alu_state_t state, state_nxt;
   alu_flags_t flags;
   logic [DATA_WIDTH-1:0] res, neg_b, mul_prod;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic accept, is_mul, mul_start, mul_done, ill, ovf, sign_b;
   assign shamt     = data_in_B[SHAMT_WIDTH-1:0];
   assign neg_b     = '0 - data_in_B;
   assign accept    = in_valid && in_ready;
   assign is_mul    = MUL_EN && ALU_ctrl == MUL;
   assign mul_start = accept && is_mul;
   // MUL falls to the default arm, so with MUL_EN=0 it becomes illegal for free
   always_comb begin
      res = '0;
      ill = 1'b0;
      case (ALU_ctrl)
         AND:     res = data_in_A & data_in_B;
         OR:      res = data_in_A | data_in_B;
         XOR:     res = data_in_A ^ data_in_B;
         ADD:     res = data_in_A + data_in_B;
         SUB:     res = data_in_A - data_in_B;
         SLL:     res = data_in_A << shamt;
         SRL:     res = data_in_A >> shamt;
         SRA:     res = $signed(data_in_A) >>> shamt;
         SLT:     res = {{M{1'b0}}, $signed(data_in_A) < $signed(data_in_B)};
         SLTU:    res = {{M{1'b0}}, data_in_A < data_in_B};
         PASSB:   res = data_in_B;
         default: ill = 1'b1;
      endcase
   end
   always_comb begin
      sign_b = ALU_ctrl == ADD ? data_in_B[M] : neg_b[M];
      ovf    = (ALU_ctrl == ADD || ALU_ctrl == SUB) && data_in_A[M] == sign_b && res[M] != data_in_A[M];
   end
   alu_mul_iter #(.W(DATA_WIDTH)) u_mul (
      .clk  (clk),
      .rst  (rst),
      .start(mul_start),
      .run  (state == MUL_BUSY),
      .a    (data_in_A),
      .b    (data_in_B),
      .prod (mul_prod),
      .done (mul_done)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state == IDLE ? (mul_start ? MUL_BUSY : IDLE) : (mul_done ? IDLE : MUL_BUSY);
   end
   always_comb begin
      in_ready = state == IDLE && (!out_valid || out_ready);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         flags     <= '0;
      end else if (accept && !is_mul) begin
         out_valid <= 1'b1;
         data_out  <= res;
         flags     <= '{zero: res == '0, negative: res[M], overflow: ovf, illegal: ill};
      end else if (mul_done) begin
         out_valid <= 1'b1;
         data_out  <= mul_prod;
         flags     <= '{zero: mul_prod == '0, negative: mul_prod[M], overflow: 1'b0, illegal: 1'b0};
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
   assign zero     = flags.zero;
   assign negative = flags.negative;
   assign overflow = flags.overflow;
   assign illegal  = flags.illegal;
endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: table-driven scoreboard bench for alu_hs, plus handshake corner sequences.
module tb_alu_hs;
   import alu_pkg::*;
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic [3:0]  f;
   } vec_t;
   typedef struct {
      logic [31:0] d;
      logic [3:0]  f;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, in_valid0 = 1'b0;
   logic [3:0] op = 4'd0;
   logic [31:0] a = '0, b = '0;
   logic in_ready, out_valid, zero, negative, overflow, illegal;
   logic in_ready0, out_valid0, zero0, negative0, overflow0, illegal0;
   logic [31:0] data_out, data_out0;
   int checks = 0, errors = 0;
   exp_t sb[$];
   vec_t tv[15];
   always #5 clk = ~clk;
   alu_hs #(.DATA_WIDTH(32), .MUL_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .data_in_A(a), .data_in_B(b), .ALU_ctrl(ALU_ctrl_t'(op)),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .zero(zero), .negative(negative), .overflow(overflow), .illegal(illegal)
   );
   alu_hs #(.DATA_WIDTH(32), .MUL_EN(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .data_in_A(a), .data_in_B(b), .ALU_ctrl(ALU_ctrl_t'(op)),
      .out_valid(out_valid0), .out_ready(1'b1), .data_out(data_out0),
      .zero(zero0), .negative(negative0), .overflow(overflow0), .illegal(illegal0)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask
   task automatic push(input logic [31:0] d, input logic [3:0] f);
      exp_t e;
      e.d = d;
      e.f = f;
      sb.push_back(e);
   endtask
   task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] d, input logic [3:0] f, output int waited);
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
         in_valid = 1'b0;
      end else begin
         push(d, f);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h want none", data_out);
         end else begin
            e = sb.pop_front();
            chk("result", data_out, e.d);
            chk("flags_znoi", {28'd0, zero, negative, overflow, illegal}, {28'd0, e.f});
         end
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int w, lat, bad;
      tv[0]  = '{ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110};
      tv[1]  = '{SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010};
      tv[2]  = '{ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000};
      tv[3]  = '{AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
      tv[4]  = '{OR,    32'h0F000000, 32'h000000F0, 32'h0F0000F0, 4'b0000};
      tv[5]  = '{XOR,   32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000};
      tv[6]  = '{SLL,   32'h00000001, 32'h00000021, 32'h00000002, 4'b0000};
      tv[7]  = '{SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
      tv[8]  = '{SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100};
      tv[9]  = '{SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
      tv[10] = '{SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000};
      tv[11] = '{PASSB, 32'h00000123, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0100};
      tv[12] = '{4'hD,  32'h00000005, 32'h00000006, 32'h00000000, 4'b1001};
      tv[13] = '{MUL,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 4'b0100};
      tv[14] = '{SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0100};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_flags", {zero, negative, overflow, illegal}, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      for (int i = 0; i < 15; i++) send(tv[i].op, tv[i].a, tv[i].b, tv[i].d, tv[i].f, w);
      drain();
      send(SUB, 32'd5, 32'd5, 32'd0, 4'b1000, w);
      send(SRA, 32'h80000000, 32'h24, 32'hF8000000, 4'b0100, w);
      chk("b2b_wait_cycles", w, 0);
      drain();
      send(MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 4'b0100, w);
      lat = 0;
      bad = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) bad++;
         @(posedge clk); #1;
         lat++;
      end
      chk("mul_latency", lat, 32);
      chk("mul_busy_in_ready_high", bad, 0);
      drain();
      out_ready = 1'b0;
      send(ADD, 32'd1, 32'd2, 32'd3, 4'b0000, w);
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_valid", out_valid, 1);
         chk("hold_data_out", data_out, 3);
         chk("hold_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      op = ADD;
      a = 32'd4;
      b = 32'd5;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("stall_in_ready", in_ready, 0);
         chk("stall_data_out", data_out, 3);
      end
      push(32'd9, 4'b0000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("after_stall_data", data_out, 9);
      drain();
      send(MUL, 32'd3, 32'd5, 32'd15, 4'b0000, w);
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) bad++;
      end
      chk("abort_no_result", bad, 0);
      send(ADD, 32'd10, 32'd20, 32'd30, 4'b0000, w);
      drain();
      op = MUL;
      a = 32'd6;
      b = 32'd7;
      in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      chk("nomul_out_valid", out_valid0, 1);
      chk("nomul_data_out", data_out0, 0);
      chk("nomul_flags", {zero0, negative0, overflow0, illegal0}, 4'b1001);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
